// File: rtl/simon_pkg.sv
// Shared types and helpers for the colour sequencer: playback states and the
// speed-to-period mapping.
package simon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } seq_state_t;

  localparam int unsigned SPEED_MAX = 32'd4;

  // Show/gap period: base halved per speed step, saturating at SPEED_MAX, never below 1.
  function automatic int unsigned period_of(input int unsigned base, input logic [2:0] speed);
    int unsigned shift;
    int unsigned p;
    shift = (32'(speed) > SPEED_MAX) ? SPEED_MAX : 32'(speed);
    p     = base >> shift;
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

endpackage

// File: rtl/colour_sequencer_tick_timer.sv
// tick_timer: reload down-counter. load latches a new period and restarts the count;
// while enabled, tc pulses on the last cycle of each period and the count reloads.
module tick_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  localparam logic [W-1:0] ONE = W'(1'b1);

  logic [W-1:0] reload_q, reload_d;
  logic [W-1:0] count_q, count_d;

  // Next count: load has priority over counting.
  always_comb begin
    reload_d = reload_q;
    count_d  = count_q;
    if (load) begin
      reload_d = load_val;
      count_d  = load_val - ONE;
    end else if (en) begin
      if (count_q == '0) begin
        count_d = reload_q - ONE;
      end else begin
        count_d = count_q - ONE;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Counter state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      reload_q <= ONE;
      count_q  <= '0;
    end else begin
      reload_q <= reload_d;
      count_q  <= count_d;
    end
  end

  assign tc = en && (count_q == '0);

endmodule

// File: rtl/colour_sequencer.sv
// colour_sequencer: stores a sequence of colours and plays it back, each entry shown
// for one period. Define COLOUR_SEQ_GAP_EN to insert a blank period after each entry.
module colour_sequencer
  import simon_pkg::*;
#(
  parameter int          DEPTH      = 32,
  parameter int          COLOUR_W   = 2,
  parameter int unsigned BASE_TICKS = 50_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [COLOUR_W-1:0]       push_colour,
  input  logic                      clear,
  input  logic                      play,
  input  logic [2:0]                speed,
  input  logic [$clog2(DEPTH)-1:0]  rd_idx,
  output logic [COLOUR_W-1:0]       rd_colour,
  output logic [$clog2(DEPTH):0]    length,
  output logic                      full,
  output logic                      overflow,
  output logic                      busy,
  output logic                      colour_valid,
  output logic [COLOUR_W-1:0]       colour,
  output logic                      done
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LEN_W  = IDX_W + 1;
  localparam int TICK_W = $clog2(BASE_TICKS + 32'd1);
  localparam logic [IDX_W-1:0] IDX_ZERO = '0;

  seq_state_t          state_q, state_d;
  logic [LEN_W-1:0]    length_q, length_d;
  logic [LEN_W-1:0]    play_len_q, play_len_d;
  logic [IDX_W-1:0]    k_q, k_d;
  logic                full_q, full_d;
  logic                overflow_q, overflow_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                done_q, done_d;
  logic [COLOUR_W-1:0] mem_q [DEPTH];

  logic                push_ok_s, tmr_load_s, tmr_tc_s, last_s;
  logic [IDX_W-1:0]    k_nxt_s;
  logic [LEN_W-1:0]    plen_s;
  logic [TICK_W-1:0]   period_s;
  logic [COLOUR_W-1:0] first_s;

  assign period_s  = TICK_W'(period_of(BASE_TICKS, speed));
  assign push_ok_s = push && !clear && !busy_q && !full_q;
  assign k_nxt_s   = k_q + IDX_W'(1'b1);
  assign last_s    = ({1'b0, k_q} + LEN_W'(1'b1)) == play_len_q;
  assign plen_s    = length_q + LEN_W'(push_ok_s);
  // A push accepted alongside play into an empty store has not reached memory yet.
  assign first_s   = (length_q == '0) ? push_colour : mem_q[IDX_ZERO];

  tick_timer #(.W(TICK_W)) u_tick_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load_s),
    .load_val (period_s),
    .en       (busy_q),
    .tc       (tmr_tc_s)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    play_len_d = play_len_q;
    k_d        = k_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    colour_d   = colour_q;
    done_d     = 1'b0;
    tmr_load_s = 1'b0;
    overflow_d = push && !clear && (busy_q || full_q);
    if (clear) begin
      length_d = '0;
    end else if (push_ok_s) begin
      length_d = length_q + LEN_W'(1'b1);
    end else begin
      length_d = length_q;
    end
    full_d = (length_d == LEN_W'(DEPTH));

    case (state_q)
      IDLE: begin
        if (play && !clear) begin
          play_len_d = plen_s;
          k_d        = '0;
          tmr_load_s = 1'b1;
          if (plen_s != '0) begin
            state_d  = SHOW;
            busy_d   = 1'b1;
            valid_d  = 1'b1;
            colour_d = first_s;
          end else begin
            state_d = FIN;
            done_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHOW: begin
        if (clear) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          valid_d  = 1'b0;
          colour_d = '0;
        end else if (tmr_tc_s) begin
`ifdef COLOUR_SEQ_GAP_EN
          state_d  = GAP;
          valid_d  = 1'b0;
          colour_d = '0;
`else
          if (last_s) begin
            state_d  = FIN;
            busy_d   = 1'b0;
            valid_d  = 1'b0;
            colour_d = '0;
            done_d   = 1'b1;
          end else begin
            k_d      = k_nxt_s;
            colour_d = mem_q[k_nxt_s];
          end
`endif
        end else begin
          state_d = SHOW;
        end
      end
      GAP: begin
        if (clear) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (tmr_tc_s) begin
          if (last_s) begin
            state_d = FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d  = SHOW;
            k_d      = k_nxt_s;
            valid_d  = 1'b1;
            colour_d = mem_q[k_nxt_s];
          end
        end else begin
          state_d = GAP;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        valid_d  = 1'b0;
        colour_d = '0;
      end
    endcase
  end

  // Control state and outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      length_q   <= '0;
      play_len_q <= '0;
      k_q        <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      colour_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      length_q   <= length_d;
      play_len_q <= play_len_d;
      k_q        <= k_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      colour_q   <= colour_d;
      done_q     <= done_d;
    end
  end

  // Colour storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[length_q[IDX_W-1:0]] <= push_colour;
    end
  end

  assign rd_colour    = mem_q[rd_idx];
  assign length       = length_q;
  assign full         = full_q;
  assign overflow     = overflow_q;
  assign busy         = busy_q;
  assign colour_valid = valid_q;
  assign colour       = colour_q;
  assign done         = done_q;

endmodule
